// File: rtl/picoram_arb_pkg.sv
// Shared types and constants for the two-master PicoRAM arbiter.
package picoram_arb_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic M0     = 1'b0;
    localparam logic M1     = 1'b1;
    localparam int   RAM_AW = 22;
endpackage

// File: rtl/picoram_arbiter_rr_arb2.sv
// Two-way grant decision: round-robin on ties, or m0-wins when fixed_prio is set.
module rr_arb2
    import picoram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    output logic       grant
);

    always_comb begin
        grant = M0;
        if (req == 2'b11) begin
            grant = fixed_prio ? M0 : ~last;
        end else if (req == 2'b10) begin
            grant = M1;
        end
    end

endmodule

// File: rtl/picoram_arbiter.sv
// Arbitrates two PicoRV-style masters onto one single-port RAM with
// registered read data; each access takes a grant cycle plus a ready cycle.
module picoram_arbiter
    import picoram_arb_pkg::*;
#(
    parameter int MEM_WORDS  = 65536,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_valid,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [33:0] ADDR_LIMIT = 34'(MEM_WORDS) * 34'd4;

    state_t      state;
    logic        last_grant;
    logic        owner_in_range;
    logic        grant;
    logic        any_req;
    logic        start;
    logic        g_in_range;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [3:0]  g_wstrb;

    rr_arb2 u_arb (
        .req        ({m1_valid, m0_valid}),
        .last       (last_grant),
        .fixed_prio (FIXED_PRIO),
        .grant      (grant)
    );

    always_comb begin
        any_req    = m0_valid | m1_valid;
        g_addr     = (grant == M1) ? m1_addr  : m0_addr;
        g_wdata    = (grant == M1) ? m1_wdata : m0_wdata;
        g_wstrb    = (grant == M1) ? m1_wstrb : m0_wstrb;
        g_in_range = {2'b00, g_addr} < ADDR_LIMIT;
        start      = !rst && (state == IDLE) && any_req;
        ram_addr   = rst ? '0 : g_addr[RAM_AW+1:2];
        ram_wdata  = rst ? '0 : g_wdata;
        ram_wen    = (start && g_in_range) ? g_wstrb : 4'b0000;
    end

    // Read data is only forwarded to the owner during its ready pulse, and
    // out-of-range accesses always return zero.
    always_comb begin
        m0_rdata = (m0_ready && owner_in_range) ? ram_rdata : 32'h0;
        m1_rdata = (m1_ready && owner_in_range) ? ram_rdata : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            owner          <= M0;
            last_grant     <= M1;
            owner_in_range <= 1'b0;
            m0_ready       <= 1'b0;
            m1_ready       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state          <= BUSY;
                        busy           <= 1'b1;
                        owner          <= grant;
                        last_grant     <= grant;
                        owner_in_range <= g_in_range;
                        m0_ready       <= (grant == M0);
                        m1_ready       <= (grant == M1);
                    end
                end
                BUSY: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/picoram_arbiter.md
PICORAM_ARBITER -- requirements
Module: picoram_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 65536, meaning RAM size in 32-bit words.
REQ-002 SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin and 1 = m0 always wins.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports m0_valid/m1_valid  input  1  master request.
REQ-006 SHALL have ports m0_addr/m1_addr  input  32  byte address.
REQ-007 SHALL have ports m0_wdata/m1_wdata  input  32  write data.
REQ-008 SHALL have ports m0_wstrb/m1_wstrb  input  4  byte enables; 0 = read.
REQ-009 SHALL have ports m0_ready/m1_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports m0_rdata/m1_rdata  output  32  read data, valid only while the matching ready is high.
REQ-011 SHALL have port ram_wen  output  4  byte write enables to the single-port RAM.
REQ-012 SHALL have port ram_addr  output  22  word address, equal to addr[23:2] of the granted master.
REQ-013 SHALL have port ram_wdata  output  32  write data to the RAM.
REQ-014 SHALL have port ram_rdata  input  32  RAM read data, registered, one-cycle latency.
REQ-015 SHALL have ports busy  output  1  and owner  output  1  (granted master index).

Function
REQ-016 SHALL implement FSM states IDLE and BUSY.
REQ-017 In IDLE with at least one valid: SHALL grant one master combinationally, drive ram_addr/ram_wdata from it, drive ram_wen = wstrb (0 if out of range), register owner, and go to BUSY.
REQ-018 In BUSY: SHALL pulse ready of owner for exactly one cycle, drive its rdata from ram_rdata (0 if out of range), then return to IDLE.
REQ-019 Latency: valid sampled in IDLE at cycle T SHALL produce ready at T+1. Maximum throughput is one access per 2 cycles.
REQ-020 Arbitration, round-robin: when both masters are valid in IDLE, SHALL grant the master not granted last. A single requester SHALL always be granted.
REQ-021 Arbitration, FIXED_PRIO=1: m0 SHALL win every tie.
REQ-022 The last-grant register SHALL update only on grant.
REQ-023 ram_wen SHALL be 0 in BUSY and in IDLE without a grant. Valid still high in BUSY SHALL NOT reissue the access.
REQ-024 Out-of-range access (addr >= 4*MEM_WORDS): SHALL complete with normal timing, no write, rdata = 0.
REQ-025 A non-granted master SHALL keep ready = 0 and wait indefinitely.
REQ-026 If the owner drops valid during BUSY, ready SHALL still pulse and the access is considered complete.
REQ-027 busy SHALL be 1 exactly when the state is BUSY.
REQ-028 rdata outputs SHALL be 0 whenever the matching ready is 0.

Reset
REQ-029 On rst: state IDLE, m0_ready = m1_ready = 0, busy = 0, owner = 0, last-grant = 1 (so m0 wins the first tie).
REQ-030 On rst asserted mid-BUSY: the pending ready SHALL be dropped. The RAM write issued in the grant cycle is not undone.
REQ-031 All outputs SHALL be at reset values while rst is high.

Structure
REQ-032 Package picoram_arb_pkg SHALL hold the state enum (IDLE, BUSY), the master index constants M0 = 0 and M1 = 1, and the RAM word-address width 22.
REQ-033 The grant decision SHALL be a sub-module rr_arb2 (inputs: req[1:0], last, fixed_prio; output: grant index). The FSM and muxing stay in picoram_arbiter.

Verification
REQ-034 Single read: m0 reads 0x0000_0400, RAM holds 0x1234_5678 -> ram_addr = 0x100 at T, m0_ready = 1 and m0_rdata = 0x1234_5678 at T+1.
REQ-035 Tie after reset: both valid at T0 -> m0 granted first, m1 granted at T0+2; m1_ready at T0+3.
REQ-036 Sustained contention, round-robin, 8 accesses each -> grants alternate m0,m1,m0,...; neither master waits more than 3 cycles.
REQ-037 Byte write: m1 write wstrb = 4'b0010, wdata = 0xAABBCCDD to 0x10 -> ram_wen = 4'b0010 for exactly one cycle; readback byte1 = 0xCC, other bytes unchanged.
REQ-038 Out of range: m0 reads 0x0004_0000 with MEM_WORDS = 65536 -> ram_wen = 0, m0_ready at T+1, m0_rdata = 0.
REQ-039 Reset in BUSY: assert rst in the BUSY cycle -> no ready pulse, busy = 0 immediately; the first tie after release goes to m0.
